// File: rtl/sbox_layer_serial_if.sv
// Request/response channel of the serial QARMAv2 S-box layer.
interface sbox_layer_serial_if #(
    parameter int unsigned STATE_W = 64
);
    logic               in_valid;
    logic               in_ready;
    logic               in_inv;
    logic [STATE_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_data;

    // Requester / result consumer side
    modport master (
        output in_valid,
        output in_inv,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // S-box layer side
    modport slave (
        input  in_valid,
        input  in_inv,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sbox_layer_serial.sv
// Serial QARMAv2 S-box layer: substitutes the 16 nibbles of a 64-bit state
// LANES at a time (forward or inverse), finishing in 16/LANES cycles.
module sbox_layer_serial #(
    parameter int unsigned STATE_W = 64,
    parameter int unsigned LANES   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    output logic               busy,
    sbox_layer_serial_if.slave bus
);

    localparam int unsigned NIBBLES = 16;
    localparam int unsigned GROUPS  = NIBBLES / LANES;
    localparam int unsigned CNT_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(GROUPS - 1);

    // Reject unsupported configurations at elaboration
    generate
        if (STATE_W != 64) begin : g_bad_width
            $error("sbox_layer_serial: STATE_W must be 64");
        end
        if ((LANES == 0) || (LANES > NIBBLES) || ((NIBBLES % LANES) != 0)) begin : g_bad_lanes
            $error("sbox_layer_serial: LANES must divide 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h4;
            4'h1: y = 4'h7;
            4'h2: y = 4'h9;
            4'h3: y = 4'hb;
            4'h4: y = 4'hc;
            4'h5: y = 4'h6;
            4'h6: y = 4'he;
            4'h7: y = 4'hf;
            4'h8: y = 4'h0;
            4'h9: y = 4'h5;
            4'ha: y = 4'h1;
            4'hb: y = 4'hd;
            4'hc: y = 4'h8;
            4'hd: y = 4'h3;
            4'he: y = 4'h2;
            default: y = 4'ha;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h8;
            4'h1: y = 4'ha;
            4'h2: y = 4'he;
            4'h3: y = 4'hd;
            4'h4: y = 4'h0;
            4'h5: y = 4'h9;
            4'h6: y = 4'h5;
            4'h7: y = 4'h1;
            4'h8: y = 4'hc;
            4'h9: y = 4'h2;
            4'ha: y = 4'hf;
            4'hb: y = 4'h3;
            4'hc: y = 4'h4;
            4'hd: y = 4'hb;
            4'he: y = 4'h6;
            default: y = 4'h7;
        endcase
        return y;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic               mode_q, mode_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [STATE_W-1:0] sub_data;

    // Shared lanes: substitute the nibble group selected by the counter
    always_comb begin
        sub_data = data_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            logic [3:0] nib_idx;
            logic [5:0] bit_base;
            logic [3:0] nib_in;
            logic [3:0] nib_out;
            nib_idx  = 4'(32'(cnt_q) * LANES + l);
            bit_base = {nib_idx, 2'b00};
            nib_in   = data_q[bit_base +: 4];
            nib_out  = mode_q ? sbox_inv(nib_in) : sbox_fwd(nib_in);
            sub_data[bit_base +: 4] = nib_out;
        end
    end

    // Next-state, datapath update and next registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        data_d  = bus.in_data;
                        mode_d  = bus.in_inv;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    data_d = sub_data;
                    if (cnt_q == LAST_GROUP) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sbox_layer_serial.sv
// Bench for sbox_layer_serial: one instance per LANES value (1,2,4,8,16),
// scoreboard queue fed by the driver, per-instance monitors checking results.
module tb_sbox_layer_serial;

    localparam int unsigned NI = 5;

    logic clk;
    logic rst_n;

    logic [NI-1:0] iv, ii, ordy, fl;
    logic [63:0]   id [NI];
    logic [NI-1:0] ir, ov, bz;
    logic [63:0]   od [NI];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc [NI];

    typedef struct {
        int          inst;
        logic [63:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    localparam logic [3:0] FWD [16] = '{4'h4, 4'h7, 4'h9, 4'hb, 4'hc, 4'h6, 4'he, 4'hf,
                                        4'h0, 4'h5, 4'h1, 4'hd, 4'h8, 4'h3, 4'h2, 4'ha};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: substitute every nibble; inverse found by searching the forward table
    function automatic logic [63:0] ref_sbox(input logic [63:0] d, input bit inv);
        logic [63:0] r;
        logic [3:0]  nib;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            nib = d[4*i +: 4];
            if (!inv) begin
                r[4*i +: 4] = FWD[nib];
            end else begin
                for (int j = 0; j < 16; j++) begin
                    if (FWD[j] == nib) r[4*i +: 4] = 4'(j);
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to instance k; expectation goes to the scoreboard
    task automatic issue_exp(input int k, input bit inv, input logic [63:0] d, input logic [63:0] exp);
        int t;
        t = 0;
        while (!ir[k] && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) chk("issue_ready_timeout", 64'(ir[k]), 64'd1);
        iv[k]      = 1'b1;
        ii[k]      = inv;
        id[k]      = d;
        acc_cyc[k] = cyc + 1;
        sb.push_back('{k, exp, 16 >> k});
        tick();
        iv[k] = 1'b0;
        ii[k] = 1'($urandom);
        id[k] = {$urandom, $urandom};
    endtask

    task automatic issue(input int k, input bit inv, input logic [63:0] d);
        issue_exp(k, inv, d, ref_sbox(d, inv));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);
    endtask

    genvar gk;
    generate
        for (gk = 0; gk < NI; gk++) begin : g
            sbox_layer_serial_if #(.STATE_W(64)) bus ();

            assign bus.in_valid  = iv[gk];
            assign bus.in_inv    = ii[gk];
            assign bus.in_data   = id[gk];
            assign bus.out_ready = ordy[gk];
            assign ir[gk]        = bus.in_ready;
            assign ov[gk]        = bus.out_valid;
            assign od[gk]        = bus.out_data;

            sbox_layer_serial #(
                .STATE_W(64),
                .LANES  (1 << gk)
            ) dut (
                .clk  (clk),
                .rst_n(rst_n),
                .flush(fl[gk]),
                .busy (bz[gk]),
                .bus  (bus)
            );

            bit   seen = 1'b0;
            int   lat_meas = 0;
            exp_t e;

            // Monitor: measure latency, pop and compare on each output handshake
            always @(negedge clk) begin
                if (!rst_n) begin
                    seen = 1'b0;
                end else begin
                    if (ov[gk] && !seen) begin
                        seen     = 1'b1;
                        lat_meas = cyc - acc_cyc[gk];
                    end
                    if (ov[gk] && ordy[gk]) begin
                        seen = 1'b0;
                        if (sb.size() == 0) begin
                            chk($sformatf("unexpected_output_l%0d", 1 << gk), od[gk], 64'hx);
                        end else begin
                            e = sb.pop_front();
                            chk($sformatf("result_inst_l%0d", 1 << gk), 64'(gk), 64'(e.inst));
                            chk($sformatf("result_data_l%0d", 1 << gk), od[gk], e.data);
                            chk($sformatf("latency_l%0d", 1 << gk), 64'(lat_meas), 64'(e.lat));
                        end
                    end
                end
            end
        end
    endgenerate

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int ov_hits;
        logic [63:0] d, e;

        rst_n = 1'b0;
        iv    = '0;
        ii    = '0;
        fl    = '0;
        ordy  = '1;
        for (int k = 0; k < NI; k++) begin
            id[k]      = '0;
            acc_cyc[k] = 0;
        end

        // Reset values on every instance
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset_in_ready", 64'(ir[k]), 64'd1);
            chk("reset_out_valid", 64'(ov[k]), 64'd0);
            chk("reset_busy", 64'(bz[k]), 64'd0);
            chk("reset_out_data", od[k], 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // Known vectors, forward and inverse
        issue_exp(0, 1'b0, 64'h0123456789ABCDEF, 64'h479BC6EF051D832A);
        issue_exp(0, 1'b1, 64'h479BC6EF051D832A, 64'h0123456789ABCDEF);
        drain();

        // Zero state on every LANES value; monitor checks latency 16/LANES
        for (int k = 0; k < NI; k++) begin
            issue_exp(k, 1'b0, 64'h0, 64'h4444444444444444);
            issue_exp(k, 1'b1, 64'h0, 64'h8888888888888888);
            drain();
        end

        // Random traffic on every LANES value
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 12; n++) begin
                issue(k, 1'($urandom), {$urandom, $urandom});
            end
            drain();
        end

        // Backpressure, and in_valid during RUN ignored
        ordy[0] = 1'b0;
        d = {$urandom, $urandom};
        e = ref_sbox(d, 1'b0);
        issue(0, 1'b0, d);
        tick();
        tick();
        iv[0] = 1'b1;
        ii[0] = 1'b1;
        id[0] = {$urandom, $urandom};
        repeat (3) begin
            @(negedge clk);
            chk("run_in_ready_low", 64'(ir[0]), 64'd0);
            chk("run_busy_high", 64'(bz[0]), 64'd1);
        end
        tick();
        iv[0] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!ov[0] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid_reached", 64'(ov[0]), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_data_stable", od[0], e);
            chk("bp_in_ready_low", 64'(ir[0]), 64'd0);
            chk("bp_out_valid_held", 64'(ov[0]), 64'd1);
        end
        tick();
        ordy[0] = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("post_handshake_in_ready", 64'(ir[0]), 64'd1);
        chk("post_handshake_out_valid", 64'(ov[0]), 64'd0);
        drain();

        // Flush mid-run discards the operation
        issue(0, 1'b0, {$urandom, $urandom});
        repeat (6) tick();
        fl[0] = 1'b1;
        void'(sb.pop_back());
        tick();
        fl[0] = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 64'(ir[0]), 64'd1);
        chk("flush_busy", 64'(bz[0]), 64'd0);
        chk("flush_out_valid", 64'(ov[0]), 64'd0);

        // Flush together with in_valid in IDLE: not accepted
        tick();
        fl[0] = 1'b1;
        iv[0] = 1'b1;
        id[0] = {$urandom, $urandom};
        tick();
        fl[0] = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("flush_idle_not_accepted", 64'(bz[0]), 64'd0);
        chk("flush_idle_in_ready", 64'(ir[0]), 64'd1);
        ov_hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0]) ov_hits++;
        end
        chk("flush_no_output", 64'(ov_hits), 64'd0);
        tick();
        issue_exp(0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA);
        drain();

        // Asynchronous reset mid-run
        issue(0, 1'b1, {$urandom, $urandom});
        repeat (4) tick();
        void'(sb.pop_back());
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", 64'(ir[0]), 64'd1);
        chk("async_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("async_rst_busy", 64'(bz[0]), 64'd0);
        chk("async_rst_out_data", od[0], 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int n = 0; n < 4; n++) begin
            issue(0, 1'($urandom), {$urandom, $urandom});
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
